// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Up/down counter over the range 0..modulus, with a synchronous clamped
//   load, wrap or saturate behaviour at the boundary, and a one-cycle
//   terminal-count pulse.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   RST_VAL  value of out while reset is asserted (< 2^WIDTH)
//
// Ports
//   clk       single rising-edge clock
//   rst       asynchronous active-low reset
//   en        count enable
//   up        direction: 1=up, 0=down
//   load      synchronous load strobe; takes priority over counting
//   load_val  value to load; clamped to modulus
//   modulus   inclusive upper limit of the count range
//   sat       0=wrap at the boundary, 1=saturate at the boundary
//   out       registered count
//   tc        registered terminal-count pulse
//   limit     combinational boundary flag for the current direction
module updown_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic             sat,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             limit
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             at_top;   // out at or above modulus
  logic             at_zero;

  assign at_top  = (out >= modulus);
  assign at_zero = (out == '0);
  assign limit   = up ? at_top : at_zero;

  // Next-state selection. Every arithmetic step is guarded by a range
  // comparison, so +1 never runs past modulus and -1 never runs below 0.
  always_comb begin
    cnt_nxt = out;
    tc_nxt  = 1'b0;
    if (load) begin
      cnt_nxt = (load_val > modulus) ? modulus : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          cnt_nxt = out + 1'b1;
          // In saturate mode the pulse marks arrival at the top, not the
          // cycles spent sitting there.
          tc_nxt  = sat && ((out + 1'b1) == modulus);
        end else if (sat) begin
          // Also pulls an out-of-range count back down to modulus.
          cnt_nxt = modulus;
        end else begin
          cnt_nxt = '0;
          tc_nxt  = 1'b1;
        end
      end else begin
        if (at_zero) begin
          // Saturate holds at 0 with tc low; wrap jumps to the top.
          cnt_nxt = sat ? '0 : modulus;
          tc_nxt  = !sat;
        end else if (out > modulus) begin
          // Modulus was lowered beneath the count: re-enter the range.
          cnt_nxt = modulus;
        end else begin
          cnt_nxt = out - 1'b1;
          tc_nxt  = sat && (out == {{(WIDTH-1){1'b0}}, 1'b1});
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= RST_CNT;
      tc  <= 1'b0;
    end else begin
      out <= cnt_nxt;
      tc  <= tc_nxt;
    end
  end

endmodule
